adder_pipe: RTL

ADDER_PIPE -- requirements
Module: adder_pipe

---
 rtl/adder_pipe.sv | 120 ++++++++++++
 1 files changed

// File: rtl/adder_pipe.sv
// Pipelined ripple adder: stage k adds slice k of A and B, carrying into stage k+1.
// Define ADDER_PIPE_SUB_EN to add the SUB input (A - B - C_IN per operation).
module adder_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_IN,
`ifdef ADDER_PIPE_SUB_EN
  input  logic             SUB,
`endif
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH:0]   CO_S
);

  localparam int SW = WIDTH / STAGES;

  function automatic logic [SW:0] add_slice(input logic [SW-1:0] x,
                                            input logic [SW-1:0] y,
                                            input logic          ci);
    return {1'b0, x} + {1'b0, y} + {{SW{1'b0}}, ci};
  endfunction

  logic [WIDTH-1:0]  b_in;
  logic              c_eff;
  logic [STAGES-1:0] vld_p;
  logic [STAGES-1:0] vld_src;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] cy_p;
  logic              nxt_cy  [STAGES];
  logic [WIDTH-1:0]  sum_p   [STAGES];
  logic [WIDTH-1:0]  nxt_sum [STAGES];
  logic [SW:0]       slice0;

  // Subtraction is folded into the operands once at entry, so it travels
  // with the operation for free.
`ifdef ADDER_PIPE_SUB_EN
  assign b_in  = SUB ? ~B : B;
  assign c_eff = SUB ? ~C_IN : C_IN;
`else
  assign b_in  = B;
  assign c_eff = C_IN;
`endif

  // A stage moves when it is empty or everything downstream of it moves.
  always_comb begin : p_adv
    logic chain;
    chain = OUT_READY;
    for (int k = STAGES - 1; k >= 0; k--) begin
      chain  = !vld_p[k] || chain;
      adv[k] = chain;
    end
  end

  assign vld_src = STAGES'({vld_p, IN_VALID});

  // ---- stage 0: lowest slice with the external carry-in ----
  assign slice0     = add_slice(A[SW-1:0], b_in[SW-1:0], c_eff);
  assign nxt_sum[0] = WIDTH'(slice0[SW-1:0]);
  assign nxt_cy[0]  = slice0[SW];

  generate
    if (STAGES > 1) begin : g_skew
      logic [WIDTH-1:0] a_p [STAGES-1];
      logic [WIDTH-1:0] b_p [STAGES-1];

      always_ff @(posedge CLK) begin
        if (adv[0]) begin
          a_p[0] <= A;
          b_p[0] <= b_in;
        end
        for (int k = 1; k < STAGES - 1; k++) begin
          if (adv[k]) begin
            a_p[k] <= a_p[k-1];
            b_p[k] <= b_p[k-1];
          end
        end
      end

      // ---- stages 1..STAGES-1: slice k plus the registered carry ----
      for (genvar k = 1; k < STAGES; k++) begin : g_stg
        logic [SW:0] slice;
        assign slice      = add_slice(a_p[k-1][k*SW +: SW], b_p[k-1][k*SW +: SW], cy_p[k-1]);
        assign nxt_sum[k] = sum_p[k-1] | (WIDTH'(slice[SW-1:0]) << (k * SW));
        assign nxt_cy[k]  = slice[SW];
      end
    end
  endgenerate

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vld_p <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (adv[k]) vld_p[k] <= vld_src[k];
      end
    end
  end

  always_ff @(posedge CLK) begin
    for (int k = 0; k < STAGES; k++) begin
      if (adv[k]) begin
        sum_p[k] <= nxt_sum[k];
        cy_p[k]  <= nxt_cy[k];
      end
    end
  end

  // ---- output: unreset payload is masked while the last stage is empty ----
  assign IN_READY  = adv[0];
  assign OUT_VALID = vld_p[STAGES-1];
  assign CO_S      = OUT_VALID ? {cy_p[STAGES-1], sum_p[STAGES-1]} : '0;

endmodule
